// File: rtl/infinitas_pkg.sv
// Shared constants and types for the expansion-port TDM links.
package infinitas_pkg;

   localparam int unsigned TDM_SLOTS    = 8;
   localparam int unsigned TDM_SLOT_W   = 32;
   localparam int unsigned TDM_SAMPLE_W = 24;

   typedef logic [TDM_SAMPLE_W-1:0] tdm_sample_t;

   typedef enum logic {
      WAIT_SYNC,
      RUN
   } tdm_state_e;

endpackage

// File: rtl/tdm_frame_buf.sv
// Shadow/active frame storage for the TDM transmitter: write port, frame swap and serial read mux.
// Build option TDM_TX_UNDERRUN_MUTE_EN: unwritten slots are muted at swap instead of repeating.
module tdm_frame_buf
   import infinitas_pkg::*;
#(
   parameter  int unsigned SLOTS    = TDM_SLOTS,
   parameter  int unsigned SLOT_W   = TDM_SLOT_W,
   parameter  int unsigned SAMPLE_W = TDM_SAMPLE_W,
   localparam int unsigned SW       = $clog2(SLOTS),
   localparam int unsigned PW       = $clog2(SLOT_W),
   localparam int unsigned CW       = SW + PW
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wr_en,
   input  logic [SW-1:0]       wr_slot,
   input  logic [SAMPLE_W-1:0] wr_data,
   input  logic                swap,
   input  logic [CW-1:0]       rd_idx,
   output logic                rd_bit,
   output logic                swap_msb,
   output logic                any_unwritten
);

`ifdef TDM_TX_UNDERRUN_MUTE_EN
   localparam bit MUTE = 1'b1;
`else
   localparam bit MUTE = 1'b0;
`endif

   logic [SAMPLE_W-1:0] shadow [SLOTS];
   logic [SAMPLE_W-1:0] active [SLOTS];
   logic [SLOTS-1:0]    written;

   logic [SW-1:0]       rd_slot;
   logic [PW-1:0]       rd_pos;
   logic [SLOT_W-1:0]   slot_word;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < SLOTS; i++) begin
            shadow[i] <= '0;
            active[i] <= '0;
         end
         written <= '0;
      end else begin
         if (swap) begin
            for (int unsigned i = 0; i < SLOTS; i++) begin
               active[i] <= (written[i] || !MUTE) ? shadow[i] : '0;
            end
            written <= '0;
         end
         // swap and write never coincide: the write port is closed on frame_start
         if (wr_en) begin
            shadow[wr_slot]  <= wr_data;
            written[wr_slot] <= 1'b1;
         end
      end
   end

   assign any_unwritten = ~&written;
   assign swap_msb      = (written[0] | ~MUTE) & shadow[0][SAMPLE_W-1];

   // Sample left-justified in the slot; SLOT_W is a power of two so ~pos == SLOT_W-1-pos
   assign rd_slot   = rd_idx[CW-1:PW];
   assign rd_pos    = rd_idx[PW-1:0];
   assign slot_word = SLOT_W'(active[rd_slot]) << (SLOT_W - SAMPLE_W);
   assign rd_bit    = slot_word[~rd_pos];

endmodule

// File: rtl/tdm_slot_tx.sv
// TDM8 serializer: frame-sync detect, bit counter, lock tracking and the registered serial output.
// Build option TDM_TX_UNDERRUN_MUTE_EN (see tdm_frame_buf) selects mute vs repeat for unwritten slots.
module tdm_slot_tx
   import infinitas_pkg::*;
#(
   parameter int unsigned SLOTS    = TDM_SLOTS,
   parameter int unsigned SLOT_W   = TDM_SLOT_W,
   parameter int unsigned SAMPLE_W = TDM_SAMPLE_W
) (
   input  logic                       x_bclk,
   input  logic                       rst,
   input  logic                       x_lrck,
   input  logic                       s_valid,
   output logic                       s_ready,
   input  logic [$clog2(SLOTS)-1:0]   s_slot,
   input  logic [SAMPLE_W-1:0]        s_data,
   output logic                       tdm_out,
   output logic                       locked,
   output logic                       underrun,
   output logic                       sync_err
);

   localparam int unsigned FRAME_LEN = SLOTS * SLOT_W;
   localparam int unsigned CW        = $clog2(FRAME_LEN);

   tdm_state_e    state;
   logic          lrck_q;
   logic          frame_start;
   logic [CW-1:0] bit_cnt;
   logic [1:0]    lock_cnt;
   logic          wr_en;
   logic          aligned;
   logic          wrap_miss;
   logic          rd_bit;
   logic          swap_msb;
   logic          any_unwritten;

   assign frame_start = x_lrck & ~lrck_q;
   assign s_ready     = ~rst & ~frame_start;
   assign wr_en       = s_valid & s_ready;

   // The FRAME_LEN-1 -> 0 wrap lands on the edge before a correctly spaced
   // frame_start, so an aligned start (and a missed one) sees bit_cnt == 0.
   assign aligned   = (bit_cnt == '0);
   assign wrap_miss = (state == RUN) & aligned & ~frame_start;

   assign locked = (lock_cnt == 2'd2);

   tdm_frame_buf #(
      .SLOTS    (SLOTS),
      .SLOT_W   (SLOT_W),
      .SAMPLE_W (SAMPLE_W)
   ) u_buf (
      .clk           (x_bclk),
      .rst           (rst),
      .wr_en         (wr_en),
      .wr_slot       (s_slot),
      .wr_data       (s_data),
      .swap          (frame_start),
      .rd_idx        (bit_cnt),
      .rd_bit        (rd_bit),
      .swap_msb      (swap_msb),
      .any_unwritten (any_unwritten)
   );

   always_ff @(posedge x_bclk) begin
      if (rst) begin
         state    <= WAIT_SYNC;
         lrck_q   <= 1'b1;
         bit_cnt  <= '0;
         lock_cnt <= '0;
         tdm_out  <= 1'b0;
         underrun <= 1'b0;
         sync_err <= 1'b0;
      end else begin
         lrck_q   <= x_lrck;
         underrun <= 1'b0;
         sync_err <= 1'b0;
         if (frame_start) begin
            state    <= RUN;
            bit_cnt  <= CW'(1);
            tdm_out  <= swap_msb;
            underrun <= any_unwritten;
            if (state == RUN) begin
               if (aligned) begin
                  if (lock_cnt != 2'd2) lock_cnt <= lock_cnt + 2'd1;
               end else begin
                  lock_cnt <= '0;
                  sync_err <= 1'b1;
               end
            end
         end else begin
            bit_cnt <= bit_cnt + CW'(1);
            tdm_out <= (state == RUN) ? rd_bit : 1'b0;
            if (wrap_miss) begin
               lock_cnt <= '0;
               sync_err <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_tdm_slot_tx.sv
// Self-checking bench for tdm_slot_tx: frame-level reference model, randomized sample data.
module tb_tdm_slot_tx;
   import infinitas_pkg::*;

   localparam int unsigned FL = TDM_SLOTS * TDM_SLOT_W;
   localparam int unsigned SW = $clog2(TDM_SLOTS);
`ifdef TDM_TX_UNDERRUN_MUTE_EN
   localparam bit MUTE = 1'b1;
`else
   localparam bit MUTE = 1'b0;
`endif

   logic          x_bclk  = 1'b0;
   logic          rst     = 1'b1;
   logic          x_lrck  = 1'b0;
   logic          s_valid = 1'b0;
   logic [SW-1:0] s_slot  = '0;
   tdm_sample_t   s_data  = '0;
   logic          s_ready, tdm_out, locked, underrun, sync_err;

   int total = 0;
   int bad   = 0;

   // reference model: shadow, written flags and the frame currently on the wire
   tdm_sample_t sh  [TDM_SLOTS];
   tdm_sample_t act [TDM_SLOTS];
   bit          wr  [TDM_SLOTS];
   int unsigned q_slot [$];
   tdm_sample_t q_data [$];

   bit   cap  [FL];
   bit   capa [FL];
   int   und_cnt, und_first, sync_cnt, sync_first, ones_cnt;
   logic locked0, ready0, ready1;

   always #5 x_bclk = ~x_bclk;

   tdm_slot_tx #(
      .SLOTS    (TDM_SLOTS),
      .SLOT_W   (TDM_SLOT_W),
      .SAMPLE_W (TDM_SAMPLE_W)
   ) dut (
      .x_bclk   (x_bclk),
      .rst      (rst),
      .x_lrck   (x_lrck),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .s_slot   (s_slot),
      .s_data   (s_data),
      .tdm_out  (tdm_out),
      .locked   (locked),
      .underrun (underrun),
      .sync_err (sync_err)
   );

   task automatic model_clear();
      for (int i = 0; i < int'(TDM_SLOTS); i++) begin
         sh[i] = '0; act[i] = '0; wr[i] = 1'b0;
      end
      q_slot.delete();
      q_data.delete();
   endtask

   task automatic queue_writes(input int n, input bit fixed);
      for (int s = 0; s < n; s++) begin
         q_slot.push_back(s);
         q_data.push_back(fixed ? tdm_sample_t'(24'hA00000 + s) : tdm_sample_t'($urandom));
      end
   endtask

   // mode 0: lrck low, 1: one rise at m=0 (high for first half), 2: lrck held high
   task automatic run_frame(input int len, input int mode);
      und_cnt = 0; und_first = -1; sync_cnt = 0; sync_first = -1; ones_cnt = 0;
      for (int m = 0; m < len; m++) begin
         bit fs;
         bit acc;
         x_lrck  = (mode == 2) || (mode == 1 && m < len / 2);
         fs      = (mode == 1 && m == 0);
         s_valid = (q_slot.size() != 0);
         if (s_valid) begin
            s_slot = SW'(q_slot[0]);
            s_data = q_data[0];
         end
         #1;
         if (m == 0) ready0 = s_ready;
         if (m == 1) ready1 = s_ready;
         acc = s_valid && !fs;
         if (fs) begin
            for (int i = 0; i < int'(TDM_SLOTS); i++) begin
               act[i] = (wr[i] || !MUTE) ? sh[i] : '0;
               wr[i]  = 1'b0;
            end
         end
         if (acc) begin
            sh[q_slot[0]] = q_data[0];
            wr[q_slot[0]] = 1'b1;
            void'(q_slot.pop_front());
            void'(q_data.pop_front());
         end
         @(posedge x_bclk); #1;
         cap[m] = tdm_out;
         if (m == 0) locked0 = locked;
         if (tdm_out) ones_cnt++;
         if (underrun) begin und_cnt++; if (und_first < 0) und_first = m; end
         if (sync_err) begin sync_cnt++; if (sync_first < 0) sync_first = m; end
      end
      s_valid = 1'b0;
   endtask

   // bits of the captured frame that differ from the model frame (MSB first, zero tail per slot)
   function automatic int frame_mism(input int len);
      int n = 0;
      for (int m = 0; m < len; m++) begin
         int k;
         int s;
         bit e;
         k = m % int'(TDM_SLOT_W);
         s = m / int'(TDM_SLOT_W);
         e = 1'b0;
         if (k < int'(TDM_SAMPLE_W)) e = act[s][int'(TDM_SAMPLE_W) - 1 - k];
         if (cap[m] != e) n++;
      end
      return n;
   endfunction

   function automatic tdm_sample_t cap_sample(input int s);
      tdm_sample_t v;
      for (int k = 0; k < int'(TDM_SAMPLE_W); k++) v[int'(TDM_SAMPLE_W) - 1 - k] = cap[s * int'(TDM_SLOT_W) + k];
      return v;
   endfunction

   task automatic test_reset();
      rst = 1'b1; x_lrck = 1'b1; s_valid = 1'b1; s_slot = '0; s_data = tdm_sample_t'($urandom);
      repeat (3) begin @(posedge x_bclk); #1; end
      total++; if (tdm_out !== 1'b0)  begin bad++; $display("FAIL reset_tdm: got %b want 0", tdm_out); end
      total++; if (locked !== 1'b0)   begin bad++; $display("FAIL reset_locked: got %b want 0", locked); end
      total++; if (underrun !== 1'b0) begin bad++; $display("FAIL reset_underrun: got %b want 0", underrun); end
      total++; if (sync_err !== 1'b0) begin bad++; $display("FAIL reset_sync_err: got %b want 0", sync_err); end
      total++; if (s_ready !== 1'b0)  begin bad++; $display("FAIL reset_ready: got %b want 0", s_ready); end
      s_valid = 1'b0; x_lrck = 1'b0; rst = 1'b0;
      model_clear();
      run_frame(8, 0);
      total++; if (ones_cnt !== 0) begin bad++; $display("FAIL wait_sync_quiet: got %0d ones want 0", ones_cnt); end
   endtask

   task automatic test_basic_frame();
      int slot_bad = 0;
      int und_sum  = 0;
      int sync_sum = 0;
      queue_writes(TDM_SLOTS, 1'b1);
      run_frame(20, 0);
      queue_writes(TDM_SLOTS, 1'b0);
      run_frame(FL, 1);
      for (int s = 0; s < int'(TDM_SLOTS); s++) begin
         logic [31:0] want;
         logic [31:0] got;
         want = {24'hA00000 + 24'(s), 8'h00};
         for (int k = 0; k < 32; k++) got[31 - k] = cap[s * 32 + k];
         if (got !== want) slot_bad++;
      end
      total++; if (slot_bad !== 0) begin bad++; $display("FAIL basic_slots: got %0d bad slots want 0", slot_bad); end
      total++; if (locked0 !== 1'b0) begin bad++; $display("FAIL basic_locked_f1: got %b want 0", locked0); end
      und_sum += und_cnt; sync_sum += sync_cnt;
      queue_writes(TDM_SLOTS, 1'b0);
      run_frame(FL, 1);
      total++; if (frame_mism(FL) !== 0) begin bad++; $display("FAIL basic_frame2: got %0d bad bits want 0", frame_mism(FL)); end
      total++; if (locked0 !== 1'b0) begin bad++; $display("FAIL basic_locked_f2: got %b want 0", locked0); end
      und_sum += und_cnt; sync_sum += sync_cnt;
      queue_writes(TDM_SLOTS, 1'b0);
      run_frame(FL, 1);
      total++; if (frame_mism(FL) !== 0) begin bad++; $display("FAIL basic_frame3: got %0d bad bits want 0", frame_mism(FL)); end
      total++; if (locked0 !== 1'b1) begin bad++; $display("FAIL basic_locked_f3: got %b want 1", locked0); end
      und_sum += und_cnt; sync_sum += sync_cnt;
      total++; if (und_sum !== 0)  begin bad++; $display("FAIL basic_underrun: got %0d pulses want 0", und_sum); end
      total++; if (sync_sum !== 0) begin bad++; $display("FAIL basic_sync_err: got %0d pulses want 0", sync_sum); end
   endtask

   task automatic test_write_at_frame_start();
      tdm_sample_t v0;
      queue_writes(TDM_SLOTS, 1'b0);
      v0 = q_data[0];
      run_frame(FL, 1);
      total++; if (ready0 !== 1'b0) begin bad++; $display("FAIL wfs_ready_at_start: got %b want 0", ready0); end
      total++; if (ready1 !== 1'b1) begin bad++; $display("FAIL wfs_ready_next: got %b want 1", ready1); end
      total++; if (cap_sample(0) === v0 && v0 !== act[0]) begin bad++; $display("FAIL wfs_too_early: got %h want %h", cap_sample(0), act[0]); end
      queue_writes(TDM_SLOTS, 1'b0);
      run_frame(FL, 1);
      total++; if (cap_sample(0) !== v0) begin bad++; $display("FAIL wfs_slot0: got %h want %h", cap_sample(0), v0); end
      total++; if (frame_mism(FL) !== 0) begin bad++; $display("FAIL wfs_frame: got %0d bad bits want 0", frame_mism(FL)); end
   endtask

   task automatic test_underrun();
      tdm_sample_t want7;
      queue_writes(TDM_SLOTS - 1, 1'b0);
      run_frame(FL, 1);
      total++; if (und_cnt !== 0) begin bad++; $display("FAIL und_pre: got %0d pulses want 0", und_cnt); end
      want7 = MUTE ? '0 : sh[TDM_SLOTS - 1];
      queue_writes(TDM_SLOTS, 1'b0);
      run_frame(FL, 1);
      total++; if (und_cnt !== 1 || und_first !== 0) begin bad++; $display("FAIL und_pulse: got %0d pulses at %0d want 1 at 0", und_cnt, und_first); end
      total++; if (cap_sample(TDM_SLOTS - 1) !== want7) begin bad++; $display("FAIL und_slot7: got %h want %h", cap_sample(TDM_SLOTS - 1), want7); end
      total++; if (frame_mism(FL) !== 0) begin bad++; $display("FAIL und_frame: got %0d bad bits want 0", frame_mism(FL)); end
      queue_writes(TDM_SLOTS, 1'b0);
      run_frame(FL, 1);
      total++; if (und_cnt !== 0) begin bad++; $display("FAIL und_post: got %0d pulses want 0", und_cnt); end
   endtask

   task automatic test_misaligned();
      queue_writes(TDM_SLOTS, 1'b0);
      run_frame(FL - 5, 1);
      total++; if (sync_cnt !== 0 || locked0 !== 1'b1) begin bad++; $display("FAIL mis_pre: got sync=%0d locked=%b want 0/1", sync_cnt, locked0); end
      queue_writes(TDM_SLOTS, 1'b0);
      run_frame(FL, 1);
      total++; if (sync_cnt !== 1 || sync_first !== 0) begin bad++; $display("FAIL mis_sync_err: got %0d pulses at %0d want 1 at 0", sync_cnt, sync_first); end
      total++; if (locked0 !== 1'b0) begin bad++; $display("FAIL mis_unlock: got %b want 0", locked0); end
      total++; if (frame_mism(FL) !== 0) begin bad++; $display("FAIL mis_realign: got %0d bad bits want 0", frame_mism(FL)); end
      queue_writes(TDM_SLOTS, 1'b0);
      run_frame(FL, 1);
      total++; if (locked0 !== 1'b0 || sync_cnt !== 0) begin bad++; $display("FAIL mis_relock1: got locked=%b sync=%0d want 0/0", locked0, sync_cnt); end
      queue_writes(TDM_SLOTS, 1'b0);
      run_frame(FL, 1);
      total++; if (locked0 !== 1'b1) begin bad++; $display("FAIL mis_relock2: got %b want 1", locked0); end
   endtask

   task automatic test_missing_sync();
      int diff = 0;
      queue_writes(TDM_SLOTS, 1'b0);
      run_frame(FL, 1);
      for (int m = 0; m < int'(FL); m++) capa[m] = cap[m];
      run_frame(FL, 0);
      for (int m = 0; m < int'(FL); m++) if (cap[m] != capa[m]) diff++;
      total++; if (sync_cnt !== 1 || sync_first !== 0) begin bad++; $display("FAIL miss_sync_err: got %0d pulses at %0d want 1 at 0", sync_cnt, sync_first); end
      total++; if (locked0 !== 1'b0) begin bad++; $display("FAIL miss_unlock: got %b want 0", locked0); end
      total++; if (diff !== 0) begin bad++; $display("FAIL miss_repeat: got %0d differing bits want 0", diff); end
      queue_writes(TDM_SLOTS, 1'b0);
      run_frame(FL, 1);
      total++; if (und_cnt !== 0 || sync_cnt !== 0) begin bad++; $display("FAIL miss_resume_flags: got und=%0d sync=%0d want 0/0", und_cnt, sync_cnt); end
      total++; if (frame_mism(FL) !== 0) begin bad++; $display("FAIL miss_kept_writes: got %0d bad bits want 0", frame_mism(FL)); end
   endtask

   task automatic test_reset_midframe();
      queue_writes(TDM_SLOTS, 1'b0);
      run_frame(100, 1);
      rst = 1'b1; x_lrck = 1'b1; s_valid = 1'b0;
      @(posedge x_bclk); #1;
      total++; if (tdm_out !== 1'b0) begin bad++; $display("FAIL rmid_tdm: got %b want 0", tdm_out); end
      total++; if ({locked, underrun, sync_err} !== 3'b000) begin bad++; $display("FAIL rmid_flags: got %b want 000", {locked, underrun, sync_err}); end
      total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL rmid_ready: got %b want 0", s_ready); end
      repeat (3) begin @(posedge x_bclk); #1; end
      rst = 1'b0;
      model_clear();
      queue_writes(TDM_SLOTS, 1'b0);
      run_frame(10, 2);
      total++; if (ones_cnt !== 0 || sync_cnt !== 0 || und_cnt !== 0) begin bad++; $display("FAIL rmid_held_high: got ones=%0d sync=%0d und=%0d want 0", ones_cnt, sync_cnt, und_cnt); end
      run_frame(20, 0);
      total++; if (ones_cnt !== 0) begin bad++; $display("FAIL rmid_quiet: got %0d ones want 0", ones_cnt); end
      queue_writes(TDM_SLOTS, 1'b0);
      run_frame(FL, 1);
      total++; if (frame_mism(FL) !== 0) begin bad++; $display("FAIL rmid_first_frame: got %0d bad bits want 0", frame_mism(FL)); end
      total++; if (sync_cnt !== 0 || und_cnt !== 0 || locked0 !== 1'b0) begin bad++; $display("FAIL rmid_first_flags: got sync=%0d und=%0d locked=%b want 0/0/0", sync_cnt, und_cnt, locked0); end
   endtask

   initial begin
      model_clear();
      test_reset();
      test_basic_frame();
      test_write_at_frame_start();
      test_underrun();
      test_misaligned();
      test_missing_sync();
      test_reset_midframe();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
